memory_bus_arbiter: RTL



---
 rtl/memory_bus_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin sharing of one memory port between the core (m0) and a loader/debug master (m1)
module memory_bus_arbiter #(
  parameter int ADDRESS_SIZE = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] m0_address,
  input  logic [31:0]             m0_dataWrite,
  input  logic                    m0_writeEnable,
  input  logic                    m0_strobe,
  output logic [31:0]             m0_dataRead,
  output logic                    m0_ready,
  input  logic [ADDRESS_SIZE-1:0] m1_address,
  input  logic [31:0]             m1_dataWrite,
  input  logic                    m1_writeEnable,
  input  logic                    m1_strobe,
  output logic [31:0]             m1_dataRead,
  output logic                    m1_ready,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [31:0]             mem_dataWrite,
  output logic                    mem_writeEnable,
  output logic                    mem_strobe,
  input  logic [31:0]             mem_dataRead,
  input  logic                    mem_ready,
  output logic [1:0]              grant
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, RELEASE} state_t;
  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   pick, g0, g1;
  // state and round-robin history; reset leaves last_q=1 so m0 wins the first tie
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end
  // next state: new owners are only chosen once the memory has dropped ready
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pick    = (m0_strobe && m1_strobe) ? ~last_q : m1_strobe;
    case (state_q)
      IDLE, RELEASE: begin
        if (!mem_ready) begin
          if (m0_strobe || m1_strobe) begin
            state_d = pick ? GRANT1 : GRANT0;
            last_d  = pick;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GRANT0:  state_d = m0_strobe ? GRANT0 : RELEASE;
      GRANT1:  state_d = m1_strobe ? GRANT1 : RELEASE;
      default: state_d = IDLE;
    endcase
  end
  // owner's request passes straight through; everything else is held at zero
  always_comb begin
    g0              = (state_q == GRANT0);
    g1              = (state_q == GRANT1);
    mem_address     = g0 ? m0_address     : g1 ? m1_address     : '0;
    mem_dataWrite   = g0 ? m0_dataWrite   : g1 ? m1_dataWrite   : '0;
    mem_writeEnable = g0 ? m0_writeEnable : g1 ? m1_writeEnable : 1'b0;
    mem_strobe      = g0 ? m0_strobe      : g1 ? m1_strobe      : 1'b0;
    m0_ready        = g0 & mem_ready;
    m1_ready        = g1 & mem_ready;
    m0_dataRead     = mem_dataRead;
    m1_dataRead     = mem_dataRead;
    grant           = {g1, g0};
  end
endmodule
